ads_pio_in: RTL and testbench



---
 rtl/ads_pio_in.sv | 116 +++++++++++
 tb/tb_ads_pio_in.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ads_pio_in.sv
// ads_pio_in: Avalon-MM input port. The pins pass through a synchroniser and an
// optional per-bit debounce filter. Qualifying edges of the filtered value are
// latched into a write-1-to-clear capture register, which drives a maskable
// level interrupt.
module ads_pio_in #(
   parameter int WIDTH       = 1,
   parameter int EDGE_TYPE   = 0,
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam int CW = (DEBOUNCE >= 2) ? $clog2(DEBOUNCE) : 1;

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
   logic [WIDTH-1:0] s_last;
   logic [WIDTH-1:0] deb;
   logic [WIDTH-1:0] deb_nxt;
   logic [WIDTH-1:0] edge_hit;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecapture;
   logic [WIDTH-1:0] clr_mask;
   logic [31:0]      rd_mux;
   logic             wr;

   assign s_last = sync[SYNC_STAGES-1];
   assign wr     = chipselect & ~write_n;

   // Synchroniser chain: stage 0 samples the pins, each later stage the one before
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync <= '0;
      else          sync <= {sync[SYNC_STAGES-2:0], in_port};
   end

   generate
      if (DEBOUNCE <= 1) begin : g_nodeb
         assign deb_nxt = s_last;
      end else begin : g_deb
         for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic [CW-1:0] cnt;
            logic          differ;
            logic          done;
            assign differ     = s_last[i] ^ deb[i];
            assign done       = differ && (cnt == CW'(DEBOUNCE - 1));
            assign deb_nxt[i] = done ? s_last[i] : deb[i];
            // Count consecutive disagreeing cycles; any agreement restarts the run
            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n)           cnt <= '0;
               else if (!differ || done) cnt <= '0;
               else                    cnt <= cnt + 1'b1;
            end
         end
      end
   endgenerate

   // Filtered input value
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) deb <= '0;
      else          deb <= deb_nxt;
   end

   // Qualifying change of the filtered value, seen in the cycle it is accepted
   always_comb begin
      edge_hit = '0;
      if (EDGE_TYPE == 0)      edge_hit = deb_nxt & ~deb;
      else if (EDGE_TYPE == 1) edge_hit = ~deb_nxt & deb;
      else                     edge_hit = deb_nxt ^ deb;
   end

   assign clr_mask = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

   // Capture register: software clears with 1s, a same-cycle new edge wins
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) edgecapture <= '0;
      else          edgecapture <= (edgecapture & ~clr_mask) | edge_hit;
   end

   // Interrupt mask register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                    irqmask <= '0;
      else if (wr && address == 2'd2)  irqmask <= writedata[WIDTH-1:0];
   end

   // Level interrupt from any unmasked capture bit
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) irq <= 1'b0;
      else          irq <= |(edgecapture & irqmask);
   end

   // Read mux, zero-extended; reserved word reads 0
   always_comb begin
      rd_mux = '0;
      case (address)
         2'd0:    rd_mux = 32'(deb);
         2'd2:    rd_mux = 32'(irqmask);
         2'd3:    rd_mux = 32'(edgecapture);
         default: rd_mux = '0;
      endcase
   end

   // Registered read data, updated every cycle regardless of chipselect
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata <= '0;
      else          readdata <= rd_mux;
   end

endmodule

// File: tb/tb_ads_pio_in.sv
// Bench for ads_pio_in: three configurations share one bus and one pin vector,
// each checked every cycle against a behavioural model, plus directed checks.
module tb_ads_pio_in;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [3:0]  in_port = '0;
   logic [31:0] rdata [3];
   logic        irqs [3];

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ads_pio_in #(.WIDTH(4), .EDGE_TYPE(0), .SYNC_STAGES(2), .DEBOUNCE(0)) u0 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rdata[0]), .irq(irqs[0]));
   ads_pio_in #(.WIDTH(4), .EDGE_TYPE(1), .SYNC_STAGES(2), .DEBOUNCE(4)) u1 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rdata[1]), .irq(irqs[1]));
   ads_pio_in #(.WIDTH(4), .EDGE_TYPE(2), .SYNC_STAGES(3), .DEBOUNCE(3)) u2 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rdata[2]), .irq(irqs[2]));

   function automatic int edg(int k);
      return (k == 0) ? 0 : (k == 1) ? 1 : 2;
   endfunction
   function automatic int syn(int k);
      return (k == 2) ? 3 : 2;
   endfunction
   function automatic int dbc(int k);
      return (k == 0) ? 0 : (k == 1) ? 4 : 3;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: pin history, runs of disagreeing samples, register file
   logic [3:0]  m_hist [3][4];
   int          m_run  [3][4];
   logic [3:0]  m_deb  [3];
   logic [3:0]  m_ec   [3];
   logic [3:0]  m_mask [3];
   logic        m_irq  [3];
   logic [31:0] m_rd   [3];

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < 3; k++) begin
            m_deb[k] <= '0; m_ec[k] <= '0; m_mask[k] <= '0;
            m_irq[k] <= 1'b0; m_rd[k] <= '0;
            for (int i = 0; i < 4; i++) begin
               m_hist[k][i] <= '0; m_run[k][i] <= 0;
            end
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            logic [3:0] sl, nd, q, clr;
            int r;
            sl = m_hist[k][syn(k)-1];
            nd = m_deb[k];
            for (int b = 0; b < 4; b++) begin
               if (dbc(k) <= 1) nd[b] = sl[b];
               else begin
                  r = (sl[b] != m_deb[k][b]) ? m_run[k][b] + 1 : 0;
                  if (r >= dbc(k)) begin
                     nd[b] = sl[b];
                     r = 0;
                  end
                  m_run[k][b] <= r;
               end
            end
            if (edg(k) == 0)      q = nd & ~m_deb[k];
            else if (edg(k) == 1) q = ~nd & m_deb[k];
            else                  q = nd ^ m_deb[k];
            clr = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
            m_ec[k] <= (m_ec[k] & ~clr) | q;
            if (chipselect && !write_n && address == 2'd2) m_mask[k] <= writedata[3:0];
            m_irq[k] <= |(m_ec[k] & m_mask[k]);
            case (address)
               2'd0:    m_rd[k] <= {28'h0, m_deb[k]};
               2'd2:    m_rd[k] <= {28'h0, m_mask[k]};
               2'd3:    m_rd[k] <= {28'h0, m_ec[k]};
               default: m_rd[k] <= 32'h0;
            endcase
            m_deb[k] <= nd;
            for (int i = 1; i < 4; i++) m_hist[k][i] <= m_hist[k][i-1];
            m_hist[k][0] <= in_port;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (reset_n) begin
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("model_rd%0d", k), rdata[k], m_rd[k]);
            chk($sformatf("model_irq%0d", k), 32'(irqs[k]), 32'(m_irq[k]));
         end
      end
   end

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk); #1;
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a);
      @(negedge clk); #1;
      address = a;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   initial begin
      // Reset values
      idle(3);
      reset_n = 1'b1;
      for (int a = 0; a < 4; a++) begin
         rd(2'(a));
         chk($sformatf("reset_rd_addr%0d", a), rdata[0], 32'h0);
      end
      chk("reset_irq", 32'(irqs[0]), 32'h0);

      // Edge capture and interrupt, rising, no filter
      wr(2'd2, 32'h2);
      @(negedge clk); #1;
      address = 2'd3; in_port = 4'h2;
      repeat (3) @(negedge clk);
      chk("edge_irq_t2", 32'(irqs[0]), 32'h0);
      chk("edge_rd_t2", rdata[0], 32'h0);
      @(negedge clk);
      chk("edge_irq_t3", 32'(irqs[0]), 32'h1);
      chk("edge_ec_t3", rdata[0], 32'h2);
      rd(2'd0);
      chk("edge_data", rdata[0], 32'h2);
      wr(2'd3, 32'h2);
      chk("clr_irq_same", 32'(irqs[0]), 32'h1);
      @(negedge clk);
      chk("clr_irq_next", 32'(irqs[0]), 32'h0);

      // Debounce: 3-cycle glitch rejected by the DEBOUNCE=4 instance
      in_port = 4'h0;
      idle(20);
      wr(2'd3, 32'hF);
      in_port = 4'h1;
      idle(3);
      in_port = 4'h0;
      idle(12);
      rd(2'd0);
      chk("glitch_data", rdata[1], 32'h0);
      rd(2'd3);
      chk("glitch_ec", rdata[1], 32'h0);
      wr(2'd3, 32'hF);
      @(negedge clk); #1;
      address = 2'd0; in_port = 4'h1;
      repeat (6) @(negedge clk);
      chk("deb_data_t5", rdata[1], 32'h0);
      @(negedge clk);
      chk("deb_data_t6", rdata[1], 32'h1);

      // Falling-only and any-edge capture
      idle(10);
      rd(2'd3);
      chk("fall_ec_after_rise", rdata[1], 32'h0);
      chk("any_ec_after_rise", rdata[2], 32'h1);
      in_port = 4'h0;
      idle(12);
      rd(2'd3);
      chk("fall_ec_after_fall", rdata[1], 32'h1);

      // Simultaneous clear and new edge: the edge wins
      wr(2'd3, 32'hF);
      wr(2'd2, 32'h1);
      in_port = 4'h1;
      idle(6);
      in_port = 4'h0;
      idle(6);
      chk("simul_pre_irq", 32'(irqs[0]), 32'h1);
      in_port = 4'h1;
      idle(2);
      address = 2'd3; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
      idle(1);
      chipselect = 1'b0; write_n = 1'b1;
      chk("simul_irq_t2", 32'(irqs[0]), 32'h1);
      @(negedge clk);
      chk("simul_irq_t3", 32'(irqs[0]), 32'h1);
      chk("simul_ec_t3", rdata[0], 32'h1);

      // Masking and reserved address
      wr(2'd2, 32'h0);
      chk("mask_irq_same", 32'(irqs[0]), 32'h1);
      @(negedge clk);
      chk("mask_irq_next", 32'(irqs[0]), 32'h0);
      wr(2'd1, 32'hFFFF_FFFF);
      rd(2'd1);
      chk("reserved_rd", rdata[0], 32'h0);
      wr(2'd2, 32'hFFFF_FFFF);
      rd(2'd2);
      chk("mask_rd", rdata[0], 32'hF);

      // Randomised traffic checked by the model
      for (int c = 0; c < 2500; c++) begin
         @(negedge clk); #1;
         chipselect = 1'b0; write_n = 1'b1;
         address = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) in_port = 4'($urandom);
         if ($urandom_range(0, 5) == 0) begin
            chipselect = 1'b1; write_n = 1'b0;
            writedata = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
         end else if ($urandom_range(0, 9) == 0) begin
            write_n = 1'b0; writedata = 32'($urandom);
         end
      end
      @(negedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;

      // Asynchronous reset with irq high
      in_port = 4'h0;
      idle(12);
      wr(2'd3, 32'hF);
      wr(2'd2, 32'hF);
      in_port = 4'hF;
      idle(8);
      chk("pre_reset_irq", 32'(irqs[0]), 32'h1);
      reset_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("async_reset_irq%0d", k), 32'(irqs[k]), 32'h0);
         chk($sformatf("async_reset_rd%0d", k), rdata[k], 32'h0);
      end
      idle(3);
      reset_n = 1'b1;
      address = 2'd3;
      idle(20);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
